// File: rtl/port_reader.sv
// Read-side port engine: dequeues a packet head, walks its page chain, ECC-corrects
// each page through an external decoder and streams half-words with sop/eop framing.

module port_reader_word #(
  parameter int IDX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_ld,
  input  logic [15:0] raw_i,
  input  logic        out_ld,
  input  logic [15:0] out_i,
  output logic [15:0] raw_o,
  output logic [15:0] out_o
);

  logic [15:0] raw_q, out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= '0;
      out_q <= '0;
    end else begin
      if (raw_ld) raw_q <= raw_i;
      if (out_ld) out_q <= out_i;
    end
  end

  assign raw_o = raw_q;
  assign out_o = out_q;

endmodule

module port_reader #(
  parameter  int PORT_ID  = 0,
  parameter  int PRIO_NUM = 8,
  localparam int PW       = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PRIO_NUM-1:0] q_nonempty,
  output logic                deq_req,
  output logic [PW-1:0]       deq_prior,
  input  logic                deq_ack,
  input  logic [15:0]         deq_ptr,
  output logic                jt_rd_en,
  output logic [15:0]         jt_rd_addr,
  input  logic [15:0]         jt_rd_data,
  output logic [4:0]          sram_sel,
  output logic                sram_rd_en,
  output logic [13:0]         sram_rd_addr,
  input  logic [15:0]         sram_dout,
  output logic                ecc_rd_en,
  output logic [10:0]         ecc_rd_addr,
  input  logic [7:0]          ecc_dout,
  output logic [127:0]        dec_data,
  output logic [7:0]          dec_code,
  input  logic [127:0]        dec_cr_data,
  output logic                free_en,
  output logic [15:0]         free_ptr,
  input  logic                ready,
  output logic                rd_sop,
  output logic                rd_eop,
  output logic                rd_vld,
  output logic [15:0]         rd_data
);

  localparam int NUM_WORDS = 8;

  if (PORT_ID < 0 || PORT_ID > 15) begin : g_bad_port
    $error("port_reader: PORT_ID out of range");
  end

  typedef enum logic [2:0] {IDLE, ARB, FETCH, DECODE, SEND} state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] prior_q, prior_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] nxt_q, nxt_d;
  logic        first_q, first_d;
  logic [3:0]  f_q, f_d;
  logic [2:0]  w_q, w_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  code_q, code_d;

  logic                            raw_cap, out_ld;
  logic [PW-1:0]                   pick;
  logic [NUM_WORDS-1:0][15:0]      raw_w, out_w;
  logic [NUM_WORDS-1:0][15:0]      cr_w;
  logic [8:0]                      hdr_len;

  assign cr_w    = dec_cr_data;
  assign hdr_len = cr_w[0][8:0];

  // Page buffer lanes: raw words fill during FETCH, corrected words load in DECODE.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    port_reader_word #(.IDX(k)) u_word (
      .clk   (clk),
      .rst   (rst),
      .raw_ld(raw_cap && (f_q == 4'(k + 1))),
      .raw_i (sram_dout),
      .out_ld(out_ld),
      .out_i (cr_w[k]),
      .raw_o (raw_w[k]),
      .out_o (out_w[k])
    );
  end

  always_comb begin
    pick = '0;
    for (int i = PRIO_NUM - 1; i >= 0; i--)
      if (q_nonempty[i]) pick = PW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prior_q <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      first_q <= 1'b0;
      f_q     <= '0;
      w_q     <= '0;
      rem_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      prior_q <= prior_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      first_q <= first_d;
      f_q     <= f_d;
      w_q     <= w_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prior_d      = prior_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    first_d      = first_q;
    f_d          = f_q;
    w_d          = w_q;
    rem_d        = rem_q;
    code_d       = code_q;
    raw_cap      = 1'b0;
    out_ld       = 1'b0;
    deq_req      = 1'b0;
    jt_rd_en     = 1'b0;
    jt_rd_addr   = '0;
    sram_sel     = '0;
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    ecc_rd_en    = 1'b0;
    ecc_rd_addr  = '0;
    free_en      = 1'b0;
    free_ptr     = '0;
    rd_sop       = 1'b0;
    rd_eop       = 1'b0;
    rd_vld       = 1'b0;
    rd_data      = '0;

    unique case (state_q)
      IDLE: begin
        if (|q_nonempty) begin
          prior_d = pick;
          state_d = ARB;
        end
      end

      ARB: begin
        deq_req = 1'b1;
        if (deq_ack) begin
          cur_d   = deq_ptr;
          first_d = 1'b1;
          f_d     = '0;
          state_d = FETCH;
        end
      end

      // Reads are issued on f=0..7; each returns one cycle later, so f=1..8 capture.
      FETCH: begin
        if (f_q < 4'd8) begin
          sram_rd_en   = 1'b1;
          sram_sel     = cur_q[15:11];
          sram_rd_addr = {cur_q[10:0], f_q[2:0]};
        end
        if (f_q == 4'd0) begin
          ecc_rd_en   = 1'b1;
          ecc_rd_addr = cur_q[10:0];
          jt_rd_en    = 1'b1;
          jt_rd_addr  = cur_q;
        end
        if (f_q != 4'd0) raw_cap = 1'b1;
        if (f_q == 4'd1) begin
          code_d = ecc_dout;
          nxt_d  = jt_rd_data;
        end
        if (f_q == 4'd8) state_d = DECODE;
        else             f_d     = f_q + 4'd1;
      end

      DECODE: begin
        out_ld   = 1'b1;
        free_en  = 1'b1;
        free_ptr = cur_q;
        w_d      = '0;
        if (first_q) rem_d = (hdr_len == 9'd0) ? 9'd1 : hdr_len;
        state_d  = SEND;
      end

      SEND: begin
        rd_vld  = 1'b1;
        rd_data = out_w[w_q];
        rd_sop  = first_q && (w_q == 3'd0);
        rd_eop  = (rem_q == 9'd1);
        if (ready) begin
          rem_d = rem_q - 9'd1;
          w_d   = w_q + 3'd1;
          if (rem_q == 9'd1) begin
            state_d = IDLE;
          end else if (w_q == 3'd7) begin
            cur_d   = nxt_q;
            first_d = 1'b0;
            f_d     = '0;
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign deq_prior = prior_q;
  assign dec_data  = raw_w;
  assign dec_code  = code_q;

endmodule

// File: tb/tb_port_reader.sv
// Directed bench for port_reader with SRAM/jump-table/ECC memory models and a
// behavioural single-error-correcting decoder.

module tb_port_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   q_nonempty = '0;
  logic         deq_req;
  logic [2:0]   deq_prior;
  logic         deq_ack = 1'b0;
  logic [15:0]  deq_ptr = '0;
  logic         jt_rd_en;
  logic [15:0]  jt_rd_addr;
  logic [15:0]  jt_rd_data = '0;
  logic [4:0]   sram_sel;
  logic         sram_rd_en;
  logic [13:0]  sram_rd_addr;
  logic [15:0]  sram_dout = '0;
  logic         ecc_rd_en;
  logic [10:0]  ecc_rd_addr;
  logic [7:0]   ecc_dout = '0;
  logic [127:0] dec_data;
  logic [7:0]   dec_code;
  logic [127:0] dec_cr_data;
  logic         free_en;
  logic [15:0]  free_ptr;
  logic         ready = 1'b1;
  logic         rd_sop, rd_eop, rd_vld;
  logic [15:0]  rd_data;

  port_reader #(.PORT_ID(0), .PRIO_NUM(8)) dut (
    .clk(clk), .rst(rst), .q_nonempty(q_nonempty),
    .deq_req(deq_req), .deq_prior(deq_prior), .deq_ack(deq_ack), .deq_ptr(deq_ptr),
    .jt_rd_en(jt_rd_en), .jt_rd_addr(jt_rd_addr), .jt_rd_data(jt_rd_data),
    .sram_sel(sram_sel), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_dout(sram_dout), .ecc_rd_en(ecc_rd_en), .ecc_rd_addr(ecc_rd_addr),
    .ecc_dout(ecc_dout), .dec_data(dec_data), .dec_code(dec_code),
    .dec_cr_data(dec_cr_data), .free_en(free_en), .free_ptr(free_ptr),
    .ready(ready), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Toy SEC code: low 7 bits = XOR of set-bit positions, bit 7 = overall parity.
  function automatic logic [7:0] ecc_enc(input logic [127:0] d);
    logic [6:0] s = '0;
    logic       p = 1'b0;
    for (int b = 0; b < 128; b++)
      if (d[b]) begin
        s ^= 7'(b);
        p ^= 1'b1;
      end
    return {p, s};
  endfunction

  function automatic logic [127:0] ecc_fix(input logic [127:0] d, input logic [7:0] c);
    logic [127:0] r = d;
    logic [7:0]   e = ecc_enc(d);
    if (e[7] != c[7]) r[e[6:0] ^ c[6:0]] = ~r[e[6:0] ^ c[6:0]];
    return r;
  endfunction

  assign dec_cr_data = ecc_fix(dec_data, dec_code);

  // Packet word k: header carries seed tag and length, body words are {seed, k}.
  function automatic logic [15:0] pw(input int seed, input int L, input int k);
    logic [31:0] s  = seed;
    logic [31:0] l  = L;
    logic [31:0] kk = k;
    if (k == 0) return {s[6:0], l[8:0]};
    return {s[7:0], kk[7:0]};
  endfunction

  logic [15:0] sram_mem [logic [18:0]];
  logic [15:0] jt_mem   [logic [15:0]];
  logic [7:0]  ecc_mem  [logic [15:0]];
  wire  [18:0] skey = {sram_sel, sram_rd_addr};
  wire  [15:0] ekey = {sram_sel, ecc_rd_addr};

  always @(posedge clk) begin
    if (sram_rd_en) sram_dout  <= sram_mem.exists(skey) ? sram_mem[skey] : 16'hBAD0;
    if (ecc_rd_en)  ecc_dout   <= ecc_mem.exists(ekey) ? ecc_mem[ekey] : 8'h00;
    if (jt_rd_en)   jt_rd_data <= jt_mem.exists(jt_rd_addr) ? jt_mem[jt_rd_addr] : 16'h0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] xq [$];
  logic [15:0] fq [$];
  logic [18:0] aq [$];
  int          t_fetch = -1, t_vld = -1, n_jt = 0;
  logic        chk_stab = 1'b0;
  logic        hold_v = 1'b0;
  logic [17:0] held = '0;

  always @(negedge clk) begin
    if (rd_vld && ready) xq.push_back({rd_sop, rd_eop, rd_data});
    if (free_en)         fq.push_back(free_ptr);
    if (sram_rd_en)      aq.push_back({sram_sel, sram_rd_addr});
    if (jt_rd_en) begin
      n_jt++;
      if (t_fetch < 0) t_fetch = cyc;
    end
    if (rd_vld && t_vld < 0) t_vld = cyc;
    if (chk_stab && hold_v) chk("stable", {14'd0, rd_sop, rd_eop, rd_data}, {14'd0, held});
    hold_v = rd_vld && !ready;
    held   = {rd_sop, rd_eop, rd_data};
  end

  wire [224:0] all_out = {deq_req, deq_prior, jt_rd_en, jt_rd_addr, sram_sel, sram_rd_en,
                          sram_rd_addr, ecc_rd_en, ecc_rd_addr, dec_data, dec_code, free_en,
                          free_ptr, rd_sop, rd_eop, rd_vld, rd_data};

  task automatic make_pkt(input int L, input int seed, input logic [15:0] p0, p1, p2, p3,
                          input int fw, input int fb);
    logic [15:0]  pp [4];
    logic [127:0] pg;
    int           np;
    pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
    np = (L + 7) / 8;
    for (int j = 0; j < np; j++) begin
      for (int i = 0; i < 8; i++) pg[16*i +: 16] = pw(seed, L, j*8 + i);
      ecc_mem[pp[j]] = ecc_enc(pg);
      jt_mem[pp[j]]  = (j + 1 < np) ? pp[(j+1) % 4] : 16'h0;
      if (fw >= j*8 && fw < j*8 + 8) pg[16*(fw - j*8) + fb] = ~pg[16*(fw - j*8) + fb];
      for (int i = 0; i < 8; i++) sram_mem[{pp[j], 3'(i)}] = pg[16*i +: 16];
    end
  endtask

  task automatic run_pkt(input logic [7:0] qne, input int dly, input int L, input int seed,
                         input logic [2:0] eprio, input logic [15:0] p0, p1, p2, p3);
    logic [15:0] pp [4];
    int          np, n;
    pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
    np = (L + 7) / 8;
    xq.delete(); fq.delete(); aq.delete();
    t_fetch = -1; t_vld = -1; n_jt = 0;
    q_nonempty = qne;
    n = 0;
    while (!deq_req && n < 50) begin @(posedge clk); #1; n++; end
    chk("deq_req", deq_req, 1);
    chk("deq_prior", deq_prior, eprio);
    q_nonempty = 8'h01;
    repeat (dly) @(posedge clk);
    #1;
    chk("prior_hold", deq_prior, eprio);
    deq_ack = 1'b1; deq_ptr = p0;
    @(posedge clk); #1;
    deq_ack = 1'b0; deq_ptr = '0; q_nonempty = '0;
    n = 0;
    while (xq.size() < L && n < 600) begin @(posedge clk); n++; end
    #1;
    chk("vld_drop", rd_vld, 0);
    @(posedge clk); #1;
    chk("deq_idle", deq_req, 0);
    chk("xfer_cnt", xq.size(), L);
    for (int i = 0; i < L && i < xq.size(); i++) begin
      chk("data", xq[i][15:0], pw(seed, L, i));
      chk("sop", xq[i][17], (i == 0));
      chk("eop", xq[i][16], (i == L - 1));
    end
    chk("free_cnt", fq.size(), np);
    for (int j = 0; j < np && j < fq.size(); j++) chk("free_ptr", fq[j], pp[j]);
    chk("jt_cnt", n_jt, np);
    chk("latency", t_vld - t_fetch, 10);
  endtask

  logic rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, neop;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", $countones(all_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_req", deq_req, 0);

    // Single-page packet, delayed ack
    make_pkt(3, 1, 16'h0805, 16'h0, 16'h0, 16'h0, -1, 0);
    run_pkt(8'h04, 3, 3, 1, 3'd2, 16'h0805, 16'h0, 16'h0, 16'h0);
    chk("addr_cnt", aq.size(), 8);
    for (int i = 0; i < 8 && i < aq.size(); i++)
      chk("sram_addr", aq[i], {5'd1, 11'd5, 3'(i)});

    // Three-page chain
    make_pkt(17, 2, 16'h0010, 16'h0020, 16'h0031, 16'h0, -1, 0);
    run_pkt(8'h10, 0, 17, 2, 3'd4, 16'h0010, 16'h0020, 16'h0031, 16'h0);

    // Strict priority
    make_pkt(2, 3, 16'h1003, 16'h0, 16'h0, 16'h0, -1, 0);
    make_pkt(9, 9, 16'h0100, 16'h0101, 16'h0, 16'h0, -1, 0);
    run_pkt(8'h81, 1, 2, 3, 3'd0, 16'h1003, 16'h0, 16'h0, 16'h0);
    run_pkt(8'h80, 2, 9, 9, 3'd7, 16'h0100, 16'h0101, 16'h0, 16'h0);

    // Single-bit error in word3 is corrected
    make_pkt(5, 4, 16'h2007, 16'h0, 16'h0, 16'h0, 3, 5);
    run_pkt(8'h20, 0, 5, 4, 3'd5, 16'h2007, 16'h0, 16'h0, 16'h0);

    // Backpressure
    make_pkt(4, 5, 16'h0400, 16'h0, 16'h0, 16'h0, -1, 0);
    chk_stab = 1'b1;
    fork
      run_pkt(8'h02, 0, 4, 5, 3'd1, 16'h0400, 16'h0, 16'h0, 16'h0);
      begin : rdy_drv
        int n2;
        n2 = 0;
        do begin @(posedge clk); #1; n2++; end while (!rd_vld && n2 < 200);
        for (int k = 0; k < 4; k++) begin ready = rp[k]; @(posedge clk); #1; end
        ready = 1'b1;
      end
    join
    chk_stab = 1'b0;

    // Reset while word2 of an 8-word packet is on the bus
    make_pkt(8, 6, 16'h3002, 16'h0, 16'h0, 16'h0, -1, 0);
    xq.delete(); fq.delete();
    q_nonempty = 8'h10;
    n = 0;
    while (!deq_req && n < 50) begin @(posedge clk); #1; n++; end
    deq_ack = 1'b1; deq_ptr = 16'h3002;
    @(posedge clk); #1;
    deq_ack = 1'b0; deq_ptr = '0; q_nonempty = '0;
    n = 0;
    while (xq.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_wait", xq.size(), 2);
    chk("w2_shown", rd_data, pw(6, 8, 2));
    #2 rst = 1'b1;
    #1;
    chk("rst_async", $countones(all_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_req", deq_req, 0);
    chk("post_vld", rd_vld, 0);
    neop = 0;
    foreach (xq[i]) if (xq[i][16]) neop++;
    chk("no_eop", neop, 0);
    chk("rst_free", fq.size(), 1);

    // Normal operation after the abort
    make_pkt(2, 7, 16'h0806, 16'h0, 16'h0, 16'h0, -1, 0);
    run_pkt(8'h08, 1, 2, 7, 3'd3, 16'h0806, 16'h0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/port_reader.md
Name: port_reader

Overview:
- Read-side counterpart of the 16-port write controller; one instance per output port (16 total).
- Picks the highest-priority non-empty queue for its port and dequeues a packet head pointer.
- Walks the packet's page chain through the jump table, reads 8 half-words plus the ECC code per page from the owning SRAM, corrects the page through an external ecc_decoder, and streams half-words out with sop/eop/vld/ready framing.
- Releases each page back to sram_state once the page is consumed.

Parameters:
- PORT_ID, 0, output port index this instance serves (tags free requests).
- PRIO_NUM, 8, number of priority queues; queue 0 is highest.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous active-high
- q_nonempty  in  8  per-priority queue non-empty flags for this port
- deq_req  out  1  dequeue request
- deq_prior  out  3  queue being dequeued
- deq_ack  in  1  head pointer valid (may come any number of cycles after deq_req)
- deq_ptr  in  16  packet head page: {sram[4:0], page[10:0]}
- jt_rd_en  out  1  jump-table read
- jt_rd_addr  out  16  current page pointer
- jt_rd_data  in  16  next page pointer, 1-cycle latency
- sram_sel  out  5  SRAM index being read
- sram_rd_en  out  1  SRAM read strobe
- sram_rd_addr  out  14  {page[10:0], batch[2:0]}
- sram_dout  in  16  half-word, 1-cycle latency
- ecc_rd_en  out  1  ECC read strobe
- ecc_rd_addr  out  11  page
- ecc_dout  in  8  page code, 1-cycle latency
- dec_data  out  128  raw page to decoder; word k at bits [16k+15:16k]
- dec_code  out  8  code to decoder
- dec_cr_data  in  128  corrected page (combinational)
- free_en  out  1  page release pulse
- free_ptr  out  16  released {sram, page}
- ready  in  1  downstream can accept a half-word
- rd_sop  out  1  first half-word of packet
- rd_eop  out  1  last half-word of packet
- rd_vld  out  1  half-word valid
- rd_data  out  16  half-word

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-packet aborts immediately with no eop and no free. Pages already dequeued are not recovered by this block.
- States: IDLE, ARB, FETCH, DECODE, SEND.
- IDLE:
  - If any q_nonempty bit is set, go to ARB.
  - deq_prior latches the lowest set index (strict priority).
- ARB:
  - Hold deq_req=1 and deq_prior stable until deq_ack.
  - On deq_ack: latch deq_ptr as cur_ptr, set first_page=1, go to FETCH.
  - q_nonempty changing during ARB does not alter deq_prior.
- FETCH (9 cycles, f=0..8):
  - f=0..7: sram_rd_en=1, sram_sel=cur_ptr[15:11], sram_rd_addr={cur_ptr[10:0], f}.
  - f=0 only: ecc_rd_en=1, ecc_rd_addr=cur_ptr[10:0]; jt_rd_en=1, jt_rd_addr=cur_ptr.
  - f=1..8: capture sram_dout into buffer word f-1.
  - f=1: capture ecc_dout and jt_rd_data (as next_ptr).
- DECODE (1 cycle):
  - Latch dec_cr_data into out_buf.
  - free_en=1, free_ptr=cur_ptr.
  - If first_page: remaining = out_buf word0[8:0]. A value of 0 is treated as 1.
- SEND:
  - Emit words 0..n-1 of out_buf, where n = min(remaining, 8).
  - rd_vld stays high until the transfer completes; a word transfers on rd_vld & ready.
  - rd_data/rd_sop/rd_eop hold stable while ready=0.
  - rd_sop=1 on word0 of the first page only. rd_eop=1 on the word where remaining reaches 1.
  - Each transfer decrements remaining (9-bit).
- After SEND:
  - remaining==0: go to IDLE; rd_vld drops the next cycle.
  - Otherwise: cur_ptr=next_ptr, first_page=0, go to FETCH.
- Header word0 is part of the packet and is emitted. Length L counts all half-words including the header, 1..511.
- Pages per packet = ceil(L/8). Words in the last page = L mod 8, with 0 meaning 8.
- Minimum per-page latency from FETCH entry to first rd_vld: 10 cycles. There is no prefetch.
- Single-bit ECC errors are corrected by the decoder, and corrected data is what is emitted.

Test Plan:
- q_nonempty=8'h04, deq_ack after 3 cycles with deq_ptr=16'h0805 (sram1, page5), header L=3, ready=1:
  - sram_rd_addr = {5,0..7}; rd_data = header, w1, w2.
  - sop on word0, eop on word2.
  - free_ptr=16'h0805 once; then back to IDLE.
- L=17, chain 0x0010 -> 0x0020 -> 0x0031:
  - Three FETCH/DECODE/SEND rounds emitting 8, 8, 1 words.
  - eop only on word 17; free_en pulses for 0x0010, 0x0020, 0x0031 in order.
- q_nonempty=8'h81:
  - deq_prior=0 first.
  - After that packet, with 8'h80, deq_prior=7.
- Stored word3 with bit 5 flipped vs the encoded code:
  - dec_cr_data corrected; rd_data for word3 equals the original value.
- ready toggling 1,0,0,1 during SEND of L=4:
  - rd_data/rd_sop/rd_eop stable while ready=0.
  - Exactly 4 transfers.
- rst asserted during SEND of word 2 of L=8:
  - All outputs 0 asynchronously; no eop.
  - After release, IDLE with deq_req=0.
